// File: rtl/cmp_search_ctrl.sv
// Binary-search controller for a registered magnitude comparator: drives B_guess,
// consumes the lt/gt/eq flags one cycle after issue, and converges on the A operand.
module cmp_search_ctrl #(
    parameter int W      = 4,
    parameter int STEP_W = 3
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              start,
    input  logic              A_lt_B,
    input  logic              A_gt_B,
    input  logic              A_eq_B,
    output logic [W-1:0]      B_guess,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [W-1:0]      found,
    output logic [STEP_W-1:0] steps
);
    localparam logic [W-1:0] MAXV = {W{1'b1}};

    typedef enum logic [1:0] {IDLE, ISSUE, EVAL, DONE} state_t;

    state_t              state_q, state_d;
    logic [W-1:0]        lo_q, lo_d, hi_q, hi_d;
    logic [W-1:0]        guess_q, guess_d, found_q, found_d;
    logic [STEP_W-1:0]   steps_q, steps_d;
    logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [W:0]          sum;
    logic                finish;

    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_q <= IDLE;
            lo_q    <= '0;
            hi_q    <= MAXV;
            guess_q <= '0;
            found_q <= '0;
            steps_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            guess_q <= guess_d;
            found_q <= found_d;
            steps_q <= steps_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        guess_d = guess_q;
        found_d = found_q;
        steps_d = steps_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        sum     = '0;
        finish  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    lo_d    = '0;
                    hi_d    = MAXV;
                    guess_d = MAXV >> 1;
                    steps_d = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = EVAL;
            EVAL: begin
                steps_d = steps_q + STEP_W'(1);
                state_d = ISSUE;
                if (!$onehot({A_lt_B, A_gt_B, A_eq_B})) begin
                    err_d  = 1'b1;
                    finish = 1'b1;
                end else if (A_eq_B) begin
                    found_d = guess_q;
                    finish  = 1'b1;
                end else if (A_gt_B) begin
                    if (guess_q == MAXV) begin
                        err_d  = 1'b1;
                        finish = 1'b1;
                    end else begin
                        // midpoint at W+1 bits so guess+1+hi cannot wrap
                        lo_d    = guess_q + W'(1);
                        sum     = {1'b0, guess_q} + {1'b0, hi_q} + (W+1)'(1);
                        guess_d = sum[W:1];
                        if (lo_d > hi_q) begin
                            err_d  = 1'b1;
                            finish = 1'b1;
                        end
                    end
                end else begin
                    if (guess_q == '0) begin
                        err_d  = 1'b1;
                        finish = 1'b1;
                    end else begin
                        hi_d    = guess_q - W'(1);
                        sum     = {1'b0, lo_q} + {1'b0, guess_q} - (W+1)'(1);
                        guess_d = sum[W:1];
                        if (lo_q > hi_d) begin
                            err_d  = 1'b1;
                            finish = 1'b1;
                        end
                    end
                end
                if (finish) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign B_guess = guess_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign found   = found_q;
    assign steps   = steps_q;
endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Self-checking bench: a registered comparator model feeds the controller, and a
// plain binary-search model predicts the guess trace, step count and result.
module tb_cmp_search_ctrl;
    localparam int W = 4, SW = 3, MAXV = 15;

    logic          CLK = 1'b0, nRST = 1'b1, start = 1'b0;
    logic          A_lt_B, A_gt_B, A_eq_B;
    logic [W-1:0]  B_guess, found;
    logic          busy, done, err;
    logic [SW-1:0] steps;

    int   target = 0, mode = 0;
    logic clt = 1'b0, cgt = 1'b0, ceq = 1'b0;
    int   checks = 0, errors = 0, old_found = 0;
    int   m_gs[0:9];
    int   m_n, m_err, m_found;

    cmp_search_ctrl #(.W(W), .STEP_W(SW)) dut (
        .CLK(CLK), .nRST(nRST), .start(start),
        .A_lt_B(A_lt_B), .A_gt_B(A_gt_B), .A_eq_B(A_eq_B),
        .B_guess(B_guess), .busy(busy), .done(done), .err(err),
        .found(found), .steps(steps)
    );

    always #5 CLK = ~CLK;

    // registered comparator: flags reflect the guess captured on the previous edge
    always @(posedge CLK) begin
        clt <= target < int'(B_guess);
        cgt <= target > int'(B_guess);
        ceq <= target == int'(B_guess);
    end

    // fault modes: 1 all-zero, 2 lt+gt, 3 always lt, 4 always gt
    always_comb begin
        A_lt_B = clt; A_gt_B = cgt; A_eq_B = ceq;
        case (mode)
            1: begin A_lt_B = 1'b0; A_gt_B = 1'b0; A_eq_B = 1'b0; end
            2: begin A_lt_B = 1'b1; A_gt_B = 1'b1; A_eq_B = 1'b0; end
            3: begin A_lt_B = 1'b1; A_gt_B = 1'b0; A_eq_B = 1'b0; end
            4: begin A_lt_B = 1'b0; A_gt_B = 1'b1; A_eq_B = 1'b0; end
            default: ;
        endcase
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int b, input int s, input int bu,
                           input int d, input int e, input int f);
        chk({tag, ".B_guess"}, int'(B_guess), b);
        chk({tag, ".steps"},   int'(steps),   s);
        chk({tag, ".busy"},    int'(busy),    bu);
        chk({tag, ".done"},    int'(done),    d);
        chk({tag, ".err"},     int'(err),     e);
        chk({tag, ".found"},   int'(found),   f);
    endtask

    // Plain search over the integer range; m_gs[k] is the guess in force for probe k+1,
    // m_gs[m_n] is what B_guess holds after the final probe.
    function automatic void run_model(input int tgt, input int md, input int prev);
        int lo, hi, g, lt, gt, eq;
        bit fin;
        lo = 0; hi = MAXV; g = MAXV / 2;
        m_n = 0; m_err = 0; m_found = prev; fin = 0;
        while (!fin && m_n < 8) begin
            m_gs[m_n] = g;
            m_n++;
            lt = int'(tgt < g); gt = int'(tgt > g); eq = int'(tgt == g);
            case (md)
                1: begin lt = 0; gt = 0; eq = 0; end
                2: begin lt = 1; gt = 1; eq = 0; end
                3: begin lt = 1; gt = 0; eq = 0; end
                4: begin lt = 0; gt = 1; eq = 0; end
                default: ;
            endcase
            if (lt + gt + eq != 1) begin m_err = 1; fin = 1; end
            else if (eq == 1) begin m_found = g; fin = 1; end
            else if (gt == 1) begin
                if (g == MAXV) begin m_err = 1; fin = 1; end
                else begin
                    lo = g + 1; g = (lo + hi) / 2;
                    if (lo > hi) begin m_err = 1; fin = 1; end
                end
            end else begin
                if (g == 0) begin m_err = 1; fin = 1; end
                else begin
                    hi = g - 1; g = (lo + hi) / 2;
                    if (lo > hi) begin m_err = 1; fin = 1; end
                end
            end
        end
        m_gs[m_n] = g;
    endfunction

    // junk=1 keeps start high while the search is busy; it must be ignored.
    task automatic search(input int tgt, input int md, input int junk);
        string tag;
        tag = $sformatf("t%0d_m%0d", tgt, md);
        target = tgt; mode = md;
        run_model(tgt, md, old_found);
        start = 1'b1;
        for (int j = 0; j <= 2 * m_n; j++) begin
            tick();
            start = (junk != 0 && j < 2 * m_n - 2) ? 1'b1 : 1'b0;
            if (j < 2 * m_n)
                chk_all(tag, m_gs[j / 2], j / 2, 1, 0, 0, old_found);
            else
                chk_all({tag, ".end"}, m_gs[m_n], m_n, 0, 1, m_err, m_found);
        end
        old_found = m_found;
        repeat (2) tick();
        chk_all({tag, ".hold"}, m_gs[m_n], m_n, 0, 1, m_err, m_found);
    endtask

    initial begin
        repeat (2) tick();
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        nRST = 1'b0;
        tick();
        chk_all("idle", 0, 0, 0, 0, 0, 0);

        // hand-computed traces pinning the model
        run_model(15, 0, 0);
        chk("model15.n", m_n, 5);
        chk("model15.g1", m_gs[1], 11);
        chk("model15.g3", m_gs[3], 14);
        chk("model15.g4", m_gs[4], 15);
        run_model(0, 3, 4);
        chk("model_lt0.n", m_n, 4);
        chk("model_lt0.err", m_err, 1);

        search(7, 0, 0);
        chk("lit7.found", int'(found), 7);
        chk("lit7.steps", int'(steps), 1);
        search(15, 0, 0);
        chk("lit15.steps", int'(steps), 5);
        search(0, 0, 0);
        chk("lit0.steps", int'(steps), 4);
        search(9, 0, 1);
        chk("lit9.found", int'(found), 9);
        search(5, 1, 0);
        chk("lit_zero.err", int'(err), 1);
        chk("lit_zero.found", int'(found), 9);
        search(5, 2, 0);
        search(0, 3, 0);
        chk("lit_lt0.steps", int'(steps), 4);
        search(15, 4, 0);
        search(10, 0, 1);

        // reset in flight: start at e0, reset sampled at e0+3
        target = 15; mode = 0;
        start = 1'b1; tick();
        start = 1'b0; tick(); tick();
        nRST = 1'b1; tick();
        chk_all("midreset", 0, 0, 0, 0, 0, 0);
        nRST = 1'b0; tick();
        old_found = 0;
        search(15, 0, 0);
        chk("post_reset.found", int'(found), 15);

        for (int i = 0; i < 30; i++) begin
            int md;
            md = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0;
            search(int'($urandom_range(0, MAXV)), md, int'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cmp_search_ctrl.md
Name: cmp_search_ctrl

Overview:
- Successive-approximation (binary search) controller wrapped around the registered magnitude comparator.
- Drives the comparator's B input with a guess and consumes the registered A_lt_B / A_gt_B / A_eq_B flags.
- Converges on the unknown value presented on the comparator's A input.
- Reports the found value, the probe count, and an error flag for inconsistent comparator responses.

Parameters:
- W, 4, data width of A/B; search range 0 .. 2^W-1
- STEP_W, 3, width of probe counter; must hold W+1

Ports:
- CLK  input  1  clock; all state updates on posedge
- nRST  input  1  reset, synchronous, active-high
- start  input  1  request a new search; sampled only in IDLE and DONE
- A_lt_B  input  1  comparator flag: target < guess
- A_gt_B  input  1  comparator flag: target > guess
- A_eq_B  input  1  comparator flag: target == guess
- B_guess  output  W  guess driven to comparator B input (registered)
- busy  output  1  search in progress
- done  output  1  search finished; held until next accepted start
- err  output  1  valid with done; inconsistent or impossible flags
- found  output  W  result; valid when done=1 and err=0
- steps  output  STEP_W  number of probes evaluated in the last or current search

Behaviour:
- Reset (nRST=1 at posedge): state=IDLE; B_guess=0, busy=0, done=0, err=0, found=0, steps=0, lo=0, hi=2^W-1.
- Reset takes priority over everything, including a search in flight; no partial result is kept.
- States: IDLE, ISSUE, EVAL, DONE.
- IDLE/DONE with start=1:
  - lo<=0, hi<=2^W-1, B_guess<=(2^W-1)>>1 (7 for W=4), steps<=0.
  - busy<=1, done<=0, err<=0; go to ISSUE. found keeps its old value until overwritten.
- start=0 in IDLE/DONE: hold the current state; all outputs stable.
- ISSUE (1 cycle): no output change; the comparator registers the current B_guess on this edge; go to EVAL.
- EVAL (1 cycle): sample the flags; steps<=steps+1. Flag decode, with priority top to bottom:
  - Not exactly one flag high -> err<=1, DONE.
  - A_eq_B -> found<=B_guess, DONE.
  - A_gt_B: if B_guess==2^W-1 -> err<=1, DONE; else lo<=B_guess+1, B_guess<=(B_guess+1+hi)>>1, ISSUE.
  - A_lt_B: if B_guess==0 -> err<=1, DONE; else hi<=B_guess-1, B_guess<=(lo+B_guess-1)>>1, ISSUE.
  - After a gt/lt update, if the new lo > new hi -> err<=1, DONE.
- Midpoint arithmetic is computed at W+1 bits, then truncated to W bits; no wrap.
- Entering DONE: busy<=0, done<=1.
- start asserted while busy is ignored.
- Timing: start accepted at edge e0; probe k is evaluated at edge e0+2k; done=1 after edge e0+2*steps.
- Worst case for W=4 is 5 probes, so done follows 10 cycles after e0.
- The comparator's own enable input must be high during a search; all-zero flags are reported as err.

Test Plan:
- Target A=7, start pulse: B_guess=7 after e0; done=1, err=0, found=7, steps=1 after e0+2; busy high exactly 2 cycles.
- Target A=15: guesses 7,11,13,14,15 in sequence; done at e0+10, found=15, steps=5.
- Target A=0: guesses 7,3,1,0; found=0, steps=4. Then target A=9 with start held from DONE: guesses 7,11,9; found=9, steps=3, done low during the search.
- Flags forced all 0 at the first EVAL: done=1, err=1, steps=1, found unchanged. Flags lt+gt both 1: same err response.
- Reset mid-operation: nRST=1 at e0+3 during the A=15 search -> next cycle all outputs 0, state IDLE. start re-pulsed after release -> clean search, found=15, steps=5.
- start re-pulsed while busy: ignored; search completes with unchanged timing. A_lt_B forced at guess 0 -> err=1.
